// File: rtl/byte_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_mem_ctrl_if
// Purpose  : CPU-side request/response bundle for byte_mem_ctrl.
//            master = CPU memory stage, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface byte_mem_ctrl_if #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN-1:0]        req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [LEN-1:0]        resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/byte_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : byte_mem_ctrl
// Purpose  : Serialises byte/half/word load-store requests into little-endian
//            byte accesses on a byte-wide synchronous RAM, reassembles and
//            extends load data, and rejects misaligned/illegal requests.
// Revision : 1.0 - initial release
// ============================================================================
module byte_mem_ctrl #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  byte_mem_ctrl_if.slave        bus,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_TAIL = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  state_t                r_state;
  logic [1:0]            r_cnt;       // index of the byte being issued
  logic [1:0]            r_last;      // index of the final byte (N-1)
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN-1:0]        r_wdata;
  logic [LEN-1:0]        r_data;      // load bytes gathered so far
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [LEN-1:0]        r_resp_rdata;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_err;
  logic [1:0]            w_req_last;
  logic [1:0]            w_next_cnt;
  logic [1:0]            w_prev_cnt;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [LEN-1:0]        w_asm;
  logic [LEN-1:0]        w_ext;

  // Ready drops with reset so nothing is accepted while held.
  assign w_ready    = (r_state == S_IDLE) & rst;
  assign w_accept   = bus.req_valid & w_ready;
  assign w_err      = (bus.req_size == 2'b11)
                    | ((bus.req_size == c_SIZE_HALF) & bus.req_addr[0])
                    | ((bus.req_size == c_SIZE_WORD) & (bus.req_addr[1:0] != 2'b00));
  assign w_next_cnt  = r_cnt + 2'd1;
  assign w_prev_cnt  = r_cnt - 2'd1;
  assign w_next_addr = r_addr + ADDR_WIDTH'(w_next_cnt);

  // Last byte index for the incoming request: 0, 1 or 3.
  always_comb begin
    w_req_last = 2'd0;
    case (bus.req_size)
      c_SIZE_HALF: w_req_last = 2'd1;
      c_SIZE_WORD: w_req_last = 2'd3;
      default:     w_req_last = 2'd0;
    endcase
  end

  // Full load word: gathered bytes plus the final byte arriving this cycle.
  always_comb begin
    w_asm = r_data;
    w_asm[{r_last, 3'b000} +: 8] = i_mem_rdata;
  end

  // Sign/zero extension by access size; words pass through unchanged.
  always_comb begin
    w_ext = w_asm;
    case (r_size)
      c_SIZE_BYTE: w_ext = {{(LEN-8){~r_unsigned & w_asm[7]}}, w_asm[7:0]};
      c_SIZE_HALF: w_ext = {{(LEN-16){~r_unsigned & w_asm[15]}}, w_asm[15:0]};
      default:     w_ext = w_asm;
    endcase
  end

  // Control FSM; all memory strobes and response fields are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_last       <= 2'd0;
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_last     <= w_req_last;
            r_data     <= '0;
            if (w_err) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state     <= S_RUN;
              r_cnt       <= 2'd0;
              r_mem_en    <= 1'b1;
              r_mem_we    <= bus.req_write;
              r_mem_addr  <= bus.req_addr;
              r_mem_wdata <= bus.req_write ? bus.req_wdata[7:0] : 8'h00;
            end
          end
        end
        S_RUN: begin
          // Read data lags the issued address by one cycle.
          if (!r_write && (r_cnt != 2'd0)) begin
            r_data[{w_prev_cnt, 3'b000} +: 8] <= i_mem_rdata;
          end
          if (r_cnt == r_last) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_write) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= '0;
            end else begin
              r_state <= S_TAIL;
            end
          end else begin
            r_cnt       <= w_next_cnt;
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= r_write ? r_wdata[{w_next_cnt, 3'b000} +: 8] : 8'h00;
          end
        end
        S_TAIL: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_ext;
        end
        S_RESP, S_ERR: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign o_mem_en       = r_mem_en;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_byte_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_mem_ctrl
// Purpose  : Directed self-checking bench for byte_mem_ctrl with a byte RAM
//            and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_mem_ctrl;
  localparam int LEN = 32;
  localparam int AW  = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  byte_mem_ctrl_if #(.LEN(LEN), .ADDR_WIDTH(AW)) bus ();

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  byte_mem_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Byte-wide synchronous RAM; contents start at zero.
  bit [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wd;
  } mem_ev_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } resp_t;

  mem_ev_t     exp_mem  [int];
  resp_t       exp_resp [int];
  logic [7:0]  mm       [int];
  int          busy_lo = -1;
  int          busy_hi = -1;
  bit          armed   = 1'b0;
  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] mm_rd(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : 8'h00;
  endfunction

  // Little-endian assembly then extension from the access-size rules.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [AW-1:0] a);
    int          n;
    logic [31:0] v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v + (32'(mm_rd(a + AW'(k))) << (8 * k));
    if (sz == 2'b00 && !uns && v >= 32'h80)   v = v | 32'hFFFFFF00;
    if (sz == 2'b01 && !uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // Per-cycle comparison of every DUT output against the expectation tables.
  task automatic cmp_loop();
    logic exp_ready;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (exp_mem.exists(cyc)) begin
          chk("mem_en", 32'(mem_en), 32'd1);
          chk("mem_we", 32'(mem_we), 32'(exp_mem[cyc].we));
          chk("mem_addr", 32'(mem_addr), 32'(exp_mem[cyc].addr));
          if (exp_mem[cyc].we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_mem[cyc].wd));
        end else begin
          chk("mem_en_quiet", 32'(mem_en), 32'd0);
          chk("mem_we_quiet", 32'(mem_we), 32'd0);
        end
        if (exp_resp.exists(cyc)) begin
          chk("resp_valid", 32'(bus.resp_valid), 32'd1);
          chk("resp_err", 32'(bus.resp_err), 32'(exp_resp[cyc].err));
          chk("resp_rdata", bus.resp_rdata, exp_resp[cyc].rd);
        end else begin
          chk("resp_valid_quiet", 32'(bus.resp_valid), 32'd0);
        end
        if (bus.resp_valid === 1'b1) begin
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
        end
        exp_ready = rst && !(cyc > busy_lo && cyc <= busy_hi);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      end
    end
  endtask

  // Issue one request at the current cycle (called just after a rising edge).
  // abort_k > 0 pulls reset during cycle abort_k of the transaction.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [AW-1:0] a, input logic [31:0] wd, input int abort_k);
    int            acc;
    int            n;
    int            rc;
    bit            err;
    logic [AW-1:0] ak;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    last_rdata       = 32'hBAD0BAD0;
    last_err         = 1'bx;
    acc = cyc;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (err) begin
      rc = acc + 1;
      exp_resp[rc] = '{1'b1, 32'h0};
    end else begin
      for (int k = 0; k < n; k++) begin
        if (abort_k == 0 || k < abort_k) begin
          ak = a + AW'(k);
          exp_mem[acc + 1 + k] = '{wr, ak, wr ? wd[8*k +: 8] : 8'h00};
          if (wr) mm[int'(ak)] = wd[8*k +: 8];
        end
      end
      rc = wr ? acc + n + 1 : acc + n + 2;
      if (abort_k == 0) exp_resp[rc] = '{1'b0, wr ? 32'h0 : model_load(sz, uns, a)};
    end
    busy_lo = acc;
    busy_hi = (abort_k != 0) ? acc + abort_k : rc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (abort_k != 0) begin
      repeat (abort_k - 1) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end else begin
      repeat (rc - acc) @(posedge clk);
      #1;
    end
  endtask

  // Directed sequence with literal pins on the model's key results.
  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    fork
      cmp_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 17'h00010, 32'hDEADBEEF, 0);
    chk("st_word_ram", {ram[17'h13], ram[17'h12], ram[17'h11], ram[17'h10]}, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 17'h00010, 32'h0, 0);
    chk("ld_word", last_rdata, 32'hDEADBEEF);
    do_req(1'b0, 2'b00, 1'b0, 17'h00013, 32'h0, 0);
    chk("ld_byte_signed", last_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b1, 17'h00013, 32'h0, 0);
    chk("ld_byte_unsigned", last_rdata, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b0, 17'h00010, 32'h0, 0);
    chk("ld_half_signed", last_rdata, 32'hFFFFBEEF);

    do_req(1'b0, 2'b10, 1'b0, 17'h00011, 32'h0, 0);
    chk("err_word_misaligned", 32'(last_err), 32'd1);
    chk("err_word_rdata", last_rdata, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 17'h00020, 32'h0, 0);
    chk("err_size11", 32'(last_err), 32'd1);
    do_req(1'b1, 2'b01, 1'b0, 17'h00011, 32'h5555, 0);
    chk("err_half_store", 32'(last_err), 32'd1);
    chk("err_half_no_write", 32'(ram[17'h11]), 32'h000000BE);

    do_req(1'b1, 2'b01, 1'b0, 17'h1FFFE, 32'h00001234, 0);
    chk("st_half_top", {ram[17'h1FFFF], ram[17'h1FFFE]}, 32'h00001234);
    do_req(1'b0, 2'b01, 1'b1, 17'h1FFFE, 32'h0, 0);
    chk("ld_half_unsigned_top", last_rdata, 32'h00001234);

    do_req(1'b1, 2'b00, 1'b0, 17'h00040, 32'h00000080, 0);
    do_req(1'b0, 2'b00, 1'b0, 17'h00040, 32'h0, 0);
    chk("ld_byte_80_signed", last_rdata, 32'hFFFFFF80);

    do_req(1'b1, 2'b10, 1'b0, 17'h00100, 32'hCAFEF00D, 2);
    chk("abort_byte0", 32'(ram[17'h100]), 32'h0000000D);
    chk("abort_byte2", 32'(ram[17'h102]), 32'h00000000);
    chk("abort_byte3", 32'(ram[17'h103]), 32'h00000000);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 17'h00100, 32'h0, 0);
    chk("ld_after_abort", last_rdata, 32'h0000F00D);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/byte_mem_ctrl.md
Name: byte_mem_ctrl

Overview:
- Memory-access controller between the CPU memory stage and a byte-wide synchronous RAM.
- Accepts one load/store request at a time: byte, halfword or word, with signed or unsigned loads.
- Serialises each request into little-endian byte accesses, reassembles and extends load data, and returns a one-cycle response pulse.
- Rejects misaligned requests without touching memory.

Parameters:
- LEN, 32, CPU data width in bits. Must be 32.
- ADDR_WIDTH, 17, byte-address width.

Ports:
- clk  input  1  clock; all logic acts on the rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  CPU request strobe.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  LEN  store data, LSB-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  misaligned or illegal-size request; qualified by resp_valid.
- resp_rdata  output  LEN  extended load data; qualified by resp_valid.
- mem_en  output  1  RAM access enable.
- mem_we  output  1  RAM write enable; only meaningful with mem_en.
- mem_addr  output  ADDR_WIDTH  RAM byte address.
- mem_wdata  output  8  RAM write byte.
- mem_rdata  input  8  RAM read byte; valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE and the byte counter clears.
  - mem_en, mem_we, resp_valid and resp_err go to 0; resp_rdata, mem_addr and mem_wdata go to 0.
  - req_ready = (state==IDLE) & rst, so it is 0 while reset is held.
- Reset mid-operation aborts the request:
  - No response is issued.
  - Memory strobes are low from the next cycle.
  - Bytes already written stay written.
- Handshake:
  - A request is accepted when req_valid & req_ready at a clock edge. This is cycle 0.
  - All request fields are latched at acceptance.
  - req_ready is high only in IDLE.
  - resp_valid is a pulse with no backpressure.
- Byte count N: 1 for byte, 2 for half, 4 for word.
- Error conditions: req_size=11, half with addr[0]=1, or word with addr[1:0]!=00.
- States:
  - IDLE: waits for acceptance. Error request → ERR. Valid request → RUN with cnt=0.
  - RUN: each cycle drives mem_en=1, mem_we=req_write, mem_addr=addr+cnt, and for stores mem_wdata=wdata[8*cnt+7:8*cnt]; then cnt increments. Loads capture mem_rdata into byte cnt-1 when cnt>0. After cnt=N-1 is issued: store → RESP; load → TAIL.
  - TAIL (load only): mem_en=0; captures mem_rdata into byte N-1; → RESP.
  - RESP: resp_valid=1 and resp_err=0. Load: resp_rdata = assembled data, extended. Store: resp_rdata=0. → IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0; no memory access occurs; → IDLE.
- Timing:
  - Store: writes in cycles 1..N, resp_valid in cycle N+1.
  - Load: reads issued in cycles 1..N, resp_valid in cycle N+2.
  - Error: resp_valid in cycle 1.
  - Next acceptance is possible no earlier than the cycle after resp_valid.
- Extension:
  - Byte loads extend bit 7, half loads extend bit 15, with zeros when req_unsigned=1.
  - Word loads ignore req_unsigned.
- Addressing:
  - addr+cnt is computed modulo 2^ADDR_WIDTH.
  - Aligned accesses never cross the top address, so wrap occurs only for unaligned byte cases (none exist).
- mem_we is never 1 while mem_en=0.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x00010:
  - Writes EF, BE, AD, DE to 0x10..0x13 in cycles 1–4.
  - resp_valid=1 in cycle 5 with resp_err=0.
- Load word from 0x00010: resp_valid in cycle 6 with resp_rdata=0xDEADBEEF.
- Load byte from 0x00013:
  - Signed → 0xFFFFFFDE.
  - Unsigned → 0x000000DE.
  - Signed half from 0x00010 → 0xFFFFBEEF.
- Word load from 0x00011 and a req_size=11 request:
  - No mem_en pulse.
  - resp_valid and resp_err=1 in cycle 1, with resp_rdata=0.
- Store half 0x1234 at 0x1FFFE:
  - Writes 34 to 0x1FFFE and 12 to 0x1FFFF.
  - Unsigned half load from 0x1FFFE returns 0x00001234.
- Start a word store, drive rst=0 in cycle 2:
  - mem_en=0 from cycle 3.
  - No resp_valid.
  - req_ready=1 after rst returns to 1.
  - Byte 0 is written; bytes 2–3 are unchanged.
